fp_gp_share_arbiter: RTL
========================

Name: fp_gp_share_arbiter

Overview:
- Shares one single-issue fp-to-gp conversion/compare/classify unit between two requesters: requester 0 is the FP issue path, requester 1 is the integer-side FMV/compare path.
- Round-robin arbitration on the issue side.
- An owner FIFO records the grant order, so each in-order result is returned to the requester that issued it.
- Sits between the two issue sources and the unit's issue/writeback interfaces.

Parameters:
- OWNER_DEPTH, 4: owner FIFO entries (power of 2, ≥2); maximum number of outstanding operations in the unit.
- ID_W, 3: instruction id width.
- OP_W, 3: op-code width forwarded to the unit.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request
- req_ready  out  2  per-requester accept
- req_op  in  2*OP_W  op; requester r in slice [r*OP_W +: OP_W]
- req_rs1  in  64  rs1; requester r in [r*32 +: 32]
- req_rs2  in  64  rs2; requester r in [r*32 +: 32]
- req_id  in  2*ID_W  id; requester r in [r*ID_W +: ID_W]
- unit_new_request  out  1  issue strobe to the unit
- unit_ready  in  1  unit can accept an issue
- unit_op  out  OP_W  muxed op
- unit_rs1  out  32  muxed rs1
- unit_rs2  out  32  muxed rs2
- unit_id  out  ID_W  muxed id
- unit_done  in  1  unit result valid
- unit_rd  in  32  unit result
- unit_wb_id  in  ID_W  unit result id
- unit_ack  out  1  result consumed
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  32  result data (shared by both requesters)
- rsp_id  out  ID_W  result id (shared by both requesters)
- owner_err  out  1  sticky: unit_done seen while the owner FIFO was empty

Behaviour:
- Reset (rst=0 at a clk edge):
  - Owner FIFO emptied; round-robin pointer = 0 (requester 0 has priority first).
  - owner_err=0; all outputs deasserted.
- Reset mid-operation: all outstanding owner entries are discarded; the unit is reset from the same rst.
- Issue eligibility: `can_issue = unit_ready && !fifo_full`. The FIFO is full when the count equals OWNER_DEPTH.
  - A pop in the same cycle does NOT free a slot for issue: the full test uses the registered count.
- Arbitration (combinational), among valid requesters:
  - The one at the pointer wins.
  - Otherwise the other requester wins.
- Grant effects (only when can_issue):
  - `req_ready[g]=1` and `unit_new_request=1`.
  - unit_op/rs1/rs2/id come from requester g.
  - req_ready of the non-granted requester = 0.
  - With no grant, all req_ready=0 and unit_new_request=0; unit_op/rs1/rs2/id are don't-care.
- Issue handshake: completes when req_valid[g] && req_ready[g]. At that edge:
  - g is pushed into the owner FIFO.
  - pointer <= ~g.
- Response path (combinational pass-through, zero added latency):
  - head = owner FIFO head.
  - `rsp_valid[head] = unit_done && !fifo_empty`; the other rsp_valid = 0.
  - rsp_data = unit_rd; rsp_id = unit_wb_id.
  - `unit_ack = unit_done && !fifo_empty && rsp_ready[head]`.
  - On unit_ack the FIFO pops at the edge.
- Push and pop in the same cycle: count unchanged; both pointers advance modulo OWNER_DEPTH.
- Backpressure: if rsp_ready[head]=0, unit_ack stays 0. The unit holds done and blocks issue through unit_ready; the arbiter adds no extra buffering.
- Protocol error: unit_done while the FIFO is empty.
  - unit_ack=0 and rsp_valid=0.
  - owner_err is set and holds until reset.
- Latency:
  - Request to unit: 0 cycles.
  - Unit done to rsp_valid: 0 cycles.
  - Arbiter state updates 1 cycle after each handshake.

Optional Feature:
- Macro: FP_GP_ARB_STALL_CNT_EN
- Defined:
  - Adds output port `stall_cnt` (out, 16 bits).
  - Increments each cycle where |req_valid && !can_issue.
  - Saturates at 16'hFFFF; cleared to 0 on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then both req_valid=1 with unit_ready=1 for 4 cycles:
  - Grants go 0,1,0,1; unit_id follows req_id (e.g. 3'd2, 3'd5).
  - FIFO count reaches 4; issue stalls on the 5th cycle.
- Single requester: only req_valid[1]=1 for 3 cycles:
  - Three grants to requester 1.
  - Owner order 1,1,1; the three results return on rsp_valid[1] with rsp_data equal to unit_rd (e.g. 32'h7FFFFFFF).
- Backpressure: head owner 0 with rsp_ready[0]=0 for 5 cycles while unit_done=1:
  - unit_ack=0 and the FIFO is held.
  - Raising rsp_ready[0] gives unit_ack=1 in that cycle and a pop at the edge.
- FIFO full (count=4) while unit_done and rsp_ready=1 and req_valid[0]=1:
  - Pop occurs and no grant is given that cycle.
  - The grant occurs the next cycle; count ends at 4.
- unit_done=1 with the FIFO empty:
  - owner_err=1 next cycle; no rsp_valid.
  - owner_err stays 1 until rst=0, then clears.
- rst=0 asserted with 3 operations outstanding:
  - Next cycle count=0, pointer=0, all req_ready/rsp_valid=0.
  - With FP_GP_ARB_STALL_CNT_EN defined, stall_cnt=0.

Source files
------------

// File: rtl/fp_gp_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_gp_share_arbiter
//  Purpose  : Shares one in-order fp-to-gp conversion/compare/classify unit
//             between the FP issue path (requester 0) and the integer-side
//             FMV/compare path (requester 1). Issue uses round-robin
//             arbitration. An owner FIFO records the grant order so that each
//             in-order result goes back to the requester that issued it.
//  Options  : FP_GP_ARB_STALL_CNT_EN adds a saturating 16-bit stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_gp_share_arbiter #(
   parameter int OWNER_DEPTH = 4,
   parameter int ID_W        = 3,
   parameter int OP_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*OP_W-1:0] req_op,
   input  logic [63:0]       req_rs1,
   input  logic [63:0]       req_rs2,
   input  logic [2*ID_W-1:0] req_id,
   output logic              unit_new_request,
   input  logic              unit_ready,
   output logic [OP_W-1:0]   unit_op,
   output logic [31:0]       unit_rs1,
   output logic [31:0]       unit_rs2,
   output logic [ID_W-1:0]   unit_id,
   input  logic              unit_done,
   input  logic [31:0]       unit_rd,
   input  logic [ID_W-1:0]   unit_wb_id,
   output logic              unit_ack,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [ID_W-1:0]   rsp_id,
   output logic              owner_err
`ifdef FP_GP_ARB_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int PTR_W = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
   localparam int CNT_W = $clog2(OWNER_DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(OWNER_DEPTH);

   logic [OWNER_DEPTH-1:0] owner_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   rr_q;
   logic                   err_q;

   logic can_issue;
   logic grant;
   logic grant_idx;
   logic fifo_empty;
   logic head;
   logic push;
   logic pop;

   // Full test uses the registered count: a same-cycle pop never frees a slot.
   assign fifo_empty = (count_q == '0);
   assign can_issue  = unit_ready && (count_q != C_FULL_CNT);
   assign head       = owner_q[rd_ptr_q];

   // Round-robin pick: requester at the pointer wins, else the other one.
   always_comb begin
      grant_idx = req_valid[rr_q] ? rr_q : ~rr_q;
      grant     = can_issue && (req_valid != 2'b00);
   end

   // Issue-side mux and per-requester accept.
   always_comb begin
      req_ready            = 2'b00;
      req_ready[grant_idx] = grant;
      unit_new_request     = grant;
      unit_op  = grant_idx ? req_op[OP_W +: OP_W]  : req_op[0 +: OP_W];
      unit_rs1 = grant_idx ? req_rs1[32 +: 32]     : req_rs1[0 +: 32];
      unit_rs2 = grant_idx ? req_rs2[32 +: 32]     : req_rs2[0 +: 32];
      unit_id  = grant_idx ? req_id[ID_W +: ID_W]  : req_id[0 +: ID_W];
   end

   // Result steering to the FIFO-head owner with no added latency.
   always_comb begin
      rsp_valid       = 2'b00;
      rsp_valid[head] = unit_done && !fifo_empty;
      unit_ack        = unit_done && !fifo_empty && rsp_ready[head];
      rsp_data        = unit_rd;
      rsp_id          = unit_wb_id;
   end

   assign push      = grant;
   assign pop       = unit_ack;
   assign owner_err = err_q;

   // Occupancy follows push/pop; simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Owner FIFO, round-robin pointer and sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rr_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) begin
            owner_q[wr_ptr_q] <= grant_idx;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            rr_q              <= ~grant_idx;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (unit_done && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef FP_GP_ARB_STALL_CNT_EN
   logic [15:0] stall_q;

   // Count cycles where someone wants to issue but the unit path is blocked.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else if ((req_valid != 2'b00) && !can_issue && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire
